// File: rtl/input_counter.sv
// input_counter
//   Input-side frame sequencer for the 64-point FFT. Accepts one sample per
//   valid/ready handshake and generates the input-buffer write address and
//   strobe. Once a full frame is loaded it raises frame_ready and then holds
//   the buffer until the core has taken the frame (core_busy high) and
//   released it again (core_busy low).
//
// Ports
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-high reset
//   din_valid       in   source presents a sample
//   din_ready       out  sample accepted this cycle (registered)
//   core_busy       in   FFT core busy; also the frame acknowledge
//   counter_o       out  buffer write address (CNT_W bits)
//   wr_en           out  buffer write strobe = din_valid & din_ready
//   in_ctrl_all_in  out  input bus routed into buffer (registered)
//   hold_all_in     out  buffer holds contents (registered)
//   frame_ready     out  full frame loaded, request to core (registered)
//
// Build option
//   INPUT_COUNTER_BITREV_EN  defined: counter_o is the bit-reversed count
//                            (decimation-in-time load order);
//                            undefined: counter_o is the count.

module input_counter #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             core_busy,
  output logic [CNT_W-1:0] counter_o,
  output logic             wr_en,
  output logic             in_ctrl_all_in,
  output logic             hold_all_in,
  output logic             frame_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_accept;

  assign w_accept = din_valid & din_ready;
  assign wr_en    = w_accept;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      IDLE: begin
        if (!core_busy) w_state_nxt = LOAD;
      end
      LOAD: begin
        if (w_accept) begin
          // Natural CNT_W-bit wrap brings the count back to 0 for the next frame.
          w_count_nxt = r_count + CNT_W'(1);
          if (r_count == '1) w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (core_busy) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_count        <= '0;
      din_ready      <= 1'b0;
      in_ctrl_all_in <= 1'b0;
      hold_all_in    <= 1'b1;
      frame_ready    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_count        <= w_count_nxt;
      din_ready      <= (w_state_nxt == LOAD);
      in_ctrl_all_in <= (w_state_nxt == LOAD);
      hold_all_in    <= (w_state_nxt != LOAD);
      frame_ready    <= (w_state_nxt == DONE);
    end
  end

`ifdef INPUT_COUNTER_BITREV_EN
  always_comb begin
    counter_o = '0;
    for (int unsigned i = 0; i < CNT_W; i++) begin
      counter_o[i] = r_count[CNT_W-1-i];
    end
  end
`else
  always_comb begin
    counter_o = r_count;
  end
`endif

endmodule

// File: tb/tb_input_counter.sv
// Self-checking bench for input_counter: a vector table for reset and the
// first handshakes, then hand-written sequences for full frames, stalls,
// core acknowledge and asynchronous reset mid-load.

module tb_input_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_valid;
  logic       din_ready;
  logic       core_busy;
  logic [5:0] counter_o;
  logic       wr_en;
  logic       in_ctrl_all_in;
  logic       hold_all_in;
  logic       frame_ready;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  input_counter #(.CNT_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .din_valid      (din_valid),
    .din_ready      (din_ready),
    .core_busy      (core_busy),
    .counter_o      (counter_o),
    .wr_en          (wr_en),
    .in_ctrl_all_in (in_ctrl_all_in),
    .hold_all_in    (hold_all_in),
    .frame_ready    (frame_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       dv;
    logic       cb;
    logic       rdy;
    logic       wr;
    logic [5:0] cnt;
    logic       ictl;
    logic       hold;
    logic       fr;
  } vec_t;

  vec_t vt[10];

  function automatic logic [5:0] exp_addr(input int unsigned k);
    logic [5:0] c;
    logic [5:0] r;
    c = k[5:0];
`ifdef INPUT_COUNTER_BITREV_EN
    for (int j = 0; j < 6; j++) r[j] = c[5-j];
`else
    r = c;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic wr,
                         input logic [5:0] cnt, input logic ictl,
                         input logic hold, input logic fr);
    chk({tag, ".din_ready"},      64'(din_ready),      64'(rdy));
    chk({tag, ".wr_en"},          64'(wr_en),          64'(wr));
    chk({tag, ".counter_o"},      64'(counter_o),      64'(cnt));
    chk({tag, ".in_ctrl_all_in"}, 64'(in_ctrl_all_in), 64'(ictl));
    chk({tag, ".hold_all_in"},    64'(hold_all_in),    64'(hold));
    chk({tag, ".frame_ready"},    64'(frame_ready),    64'(fr));
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load n samples back-to-back starting at count 'first', checking each address.
  task automatic load_run(input string tag, input int unsigned first, input int unsigned n);
    for (int unsigned k = first; k < first + n; k++) begin
      din_valid = 1'b1;
      @(negedge clk);
      chk_all(tag, 1'b1, 1'b1, exp_addr(k), 1'b1, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    logic [63:0] seen;
    int unsigned wr_cnt;
    int unsigned dup;

    //                rst   dv    cb    rdy   wr    cnt          ictl  hold  fr
    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,        1'b0, 1'b1, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,        1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,        1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,        1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,        1'b0, 1'b1, 1'b0};
    vt[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, exp_addr(0), 1'b1, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_addr(1), 1'b1, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, exp_addr(1), 1'b1, 1'b0, 1'b0};
    vt[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,        1'b0, 1'b1, 1'b0};
    vt[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,        1'b0, 1'b1, 1'b0};

    rst = 1'b1; din_valid = 1'b0; core_busy = 1'b0;

    // Vector table: reset, idle hold with core busy, first loads, stall, re-reset.
    for (int i = 0; i < 10; i++) begin
      rst       = vt[i].rst;
      din_valid = vt[i].dv;
      core_busy = vt[i].cb;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vt[i].rdy, vt[i].wr, vt[i].cnt,
              vt[i].ictl, vt[i].hold, vt[i].fr);
      tick();
    end

    // Full continuous frame: every address exactly once, in order.
    seen = '0; dup = 0; wr_cnt = 0;
    core_busy = 1'b0;
    for (int unsigned k = 0; k < 64; k++) begin
      din_valid = 1'b1;
      @(negedge clk);
      chk_all("frame", 1'b1, 1'b1, exp_addr(k), 1'b1, 1'b0, 1'b0);
      if (wr_en) begin
        wr_cnt++;
        if (seen[counter_o]) dup++;
        seen[counter_o] = 1'b1;
      end
      tick();
    end
    chk("frame.all_addr", seen, '1);
    chk("frame.dups", 64'(dup), 64'd0);
    chk("frame.writes", 64'(wr_cnt), 64'd64);

    // DONE: source still valid but nothing accepted; acknowledge withheld.
    for (int i = 0; i < 10; i++) begin
      din_valid = 1'b1; core_busy = 1'b0;
      @(negedge clk);
      chk_all("done_wait", 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1);
      tick();
    end
    core_busy = 1'b1;
    @(negedge clk);
    chk_all("done_ack", 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk_all("idle_busy", 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    core_busy = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    chk_all("idle_release", 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    chk_all("reload", 1'b1, 1'b0, exp_addr(0), 1'b1, 1'b0, 1'b0);
    tick();

    // Stalled frame: 5 idle cycles after address 20; core_busy toggles in LOAD.
    load_run("stall_pre", 0, 21);
    for (int i = 0; i < 5; i++) begin
      din_valid = 1'b0; core_busy = i[0];
      @(negedge clk);
      chk_all("stall", 1'b1, 1'b0, exp_addr(21), 1'b1, 1'b0, 1'b0);
      tick();
    end
    core_busy = 1'b0;
    load_run("stall_post", 21, 43);
    din_valid = 1'b0; core_busy = 1'b1;
    @(negedge clk);
    chk_all("stall_done", 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1);
    tick();
    // Acknowledge already high: DONE lasted one cycle, now IDLE.
    core_busy = 1'b0;
    @(negedge clk);
    chk_all("min_gap_idle", 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    tick();

    // Asynchronous reset at address 40, between clock edges.
    load_run("rst_pre", 0, 40);
    din_valid = 1'b1;
    @(negedge clk);
    chk("rst_pre.addr40", 64'(counter_o), 64'(exp_addr(40)));
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_all("post_rst_idle", 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    tick();
    load_run("post_rst", 0, 64);
    din_valid = 1'b0;
    @(negedge clk);
    chk_all("post_rst_done", 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1);

    // Reset while DONE drops frame_ready without a clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_done.frame_ready", 64'(frame_ready), 64'd0);
    chk("rst_done.hold", 64'(hold_all_in), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_counter.md
# input_counter

Input-side frame sequencer for the 64-point FFT processor, the counterpart of the output sequencer on the result side. It accepts one complex sample per accepted handshake from the upstream source and generates the 6-bit write address and write strobe for the input buffer. It drives the input-buffer mux and hold controls, and raises a frame request to the FFT core once all 64 samples are loaded. It does not accept a new frame until the core has taken and released the previous one.

## Interface
- `CNT_W`, default 6: address width; frame length N = 2^CNT_W (64).
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `din_valid` in 1: source presents a sample this cycle.
- `din_ready` out 1: block accepts a sample this cycle (registered).
- `core_busy` in 1: FFT core is processing a frame.
- `counter_o` out CNT_W: buffer write address for the current sample (combinational from count register).
- `wr_en` out 1: buffer write strobe = `din_valid & din_ready` (combinational).
- `in_ctrl_all_in` out 1: 1 = input bus routed into buffer registers (registered).
- `hold_all_in` out 1: 1 = buffer registers hold contents (registered).
- `frame_ready` out 1: full frame loaded, request to core (registered, level until acknowledged).

## Operation
- States: IDLE, LOAD, DONE. Reset values: state IDLE, count 0, `din_ready` 0, `in_ctrl_all_in` 0, `hold_all_in` 1, `frame_ready` 0; hence `wr_en` 0 and `counter_o` 0.
- IDLE: outputs at reset values. If `core_busy`=0, go to LOAD; otherwise stay.
- LOAD: `din_ready`=1, `in_ctrl_all_in`=1, `hold_all_in`=0, `frame_ready`=0.
  - On each cycle with `din_valid`=1, the sample is written at `counter_o` and count increments by 1 (CNT_W-bit, modulo N).
  - `din_valid`=0 stalls the count with no write; there is no timeout.
- Leaving LOAD: on acceptance with count = N-1, the next state is DONE and count wraps to 0.
- DONE: `din_ready`=0, `in_ctrl_all_in`=0, `hold_all_in`=1, `frame_ready`=1.
  - Stays in DONE until `core_busy`=1 is sampled, then goes to IDLE.
  - `core_busy` is the acknowledge.
- IDLE after DONE: waits for `core_busy`=0 before re-entering LOAD. The buffer therefore holds the frame for the whole core computation.
- Samples presented while `din_ready`=0 are not written. Upstream holds them, per the valid/ready rule.

## Timing
- All transitions occur on the `clk` edge. Registered outputs reflect the new state in the same cycle the state changes.
- Reset released with `core_busy`=0: LOAD is entered at the first edge, and `din_ready`=1 from that cycle.
- Continuous `din_valid`: 64 consecutive `wr_en` cycles with addresses 0..63. `frame_ready` rises at the edge that accepts address 63, the same edge at which `din_ready` falls.
- Latency from the last sample accepted to `frame_ready`: 0 cycles after that edge.
- Minimum inter-frame gap: 1 DONE cycle (if `core_busy` is already high) + 1 IDLE cycle (if `core_busy` drops immediately).
- `core_busy`=1 already in the first DONE cycle: DONE lasts exactly 1 cycle.
- `core_busy` toggling during LOAD: ignored.
- `rst` asserted in any state, including mid-LOAD: immediate return to reset values. The partial frame is abandoned, no `frame_ready` is produced, and the next frame starts at address 0.
- `rst` asserted while DONE: `frame_ready` drops immediately.

## Configuration
- Macro: `INPUT_COUNTER_BITREV_EN`.
- Defined: `counter_o` = bit-reversal of count over CNT_W bits (count 1 → 32, count 2 → 16, count 63 → 63). The buffer is loaded in decimation-in-time order.
- Not defined: `counter_o` = count (natural order).
- Neither setting affects the FSM, handshake or timing.

## Test plan
- Reset/idle: hold `rst`=1 for 3 cycles with `din_valid`=1 → `din_ready`=0, `wr_en`=0, `hold_all_in`=1, `in_ctrl_all_in`=0, `frame_ready`=0, `counter_o`=0.
- Full frame, continuous: `core_busy`=0, `din_valid`=1 for 64 cycles → `wr_en` for 64 cycles, `counter_o` 0..63. Then `frame_ready`=1, `din_ready`=0, `hold_all_in`=1.
- Stalls: drop `din_valid` for 5 cycles after address 20 → `counter_o` stays 21 with `wr_en`=0; the frame still completes after exactly 64 writes.
- Core handshake: in DONE, hold `core_busy`=0 for 10 cycles → `frame_ready` stays 1.
  - Then `core_busy`=1 for 100 cycles → IDLE, `din_ready`=0 throughout.
  - Then `core_busy`=0 → LOAD one edge later, `counter_o`=0.
- Reset mid-load: assert `rst` asynchronously at address 40 → outputs return to reset values without a clock edge. After release, the next frame writes from 0 and `frame_ready` appears only after 64 new writes.
- With `INPUT_COUNTER_BITREV_EN`: a full frame gives addresses 0, 32, 16, 48, 8, …, 63 in that order. All 64 addresses are written exactly once.
